// File: rtl/cpu_types_pkg.sv
// Shared cache types: request address split, frame layout and cache FSM states.
package cpu_types_pkg;

  localparam int DTAG_W = 26;
  localparam int DIDX_W = 3;
  localparam int DSETS  = 8;

  typedef struct packed {
    logic [DTAG_W-1:0] tag;
    logic [DIDX_W-1:0] idx;
    logic              blkoff;
    logic [1:0]        bytoff;
  } dcachef_t;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [DTAG_W-1:0] tag;
    logic [1:0][31:0]  data;
  } dcache_frame_t;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    WB0   = 4'd1,
    WB1   = 4'd2,
    LD0   = 4'd3,
    LD1   = 4'd4,
    FLUSH = 4'd5,
    FWB0  = 4'd6,
    FWB1  = 4'd7,
    DONE  = 4'd8
  } dcache_state_t;

  function automatic logic [31:0] blk_addr(input logic [DTAG_W-1:0] tag,
                                           input logic [DIDX_W-1:0] idx,
                                           input logic              off);
    return {tag, idx, off, 2'b00};
  endfunction

endpackage

// File: rtl/dcache.sv
// 2-way set-associative write-back, write-allocate data cache with an LL/SC
// link register; on halt every dirty frame is written back, then flushed rises.
module dcache
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        datomic,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  dcache_frame_t    frames_q [2][DSETS];
  logic [DSETS-1:0] lru_q;
  logic [29:0]      link_q;
  logic             linkvalid_q;
  dcache_state_t    state_q, state_d;
  logic             victim_q, victim_d;
  logic [3:0]       cnt_q;

  dcachef_t      req_s;
  dcache_frame_t way0_s, way1_s, hitf_s, vicf_s, flf_s;
  logic          hit0_s, hit1_s, hit_s, victim_s, vic_dirty_s;
  logic          req_v_s, sc_s, ll_s, link_match_s, unused_ok_s;
  logic          wr_hit_s, lru_upd_s, fill_s, fill_word_s, fill_done_s;
  logic          link_set_s, link_clr_s, fclr_s, cnt_inc_s;

  assign req_s        = dcachef_t'(dmemaddr);
  assign unused_ok_s  = ^req_s.bytoff;
  assign way0_s       = frames_q[1'b0][req_s.idx];
  assign way1_s       = frames_q[1'b1][req_s.idx];
  assign hit0_s       = way0_s.valid && (way0_s.tag == req_s.tag);
  assign hit1_s       = way1_s.valid && (way1_s.tag == req_s.tag);
  assign hit_s        = hit0_s || hit1_s;
  assign hitf_s       = hit1_s ? way1_s : way0_s;
  // Prefer an empty way; only fall back to LRU when both ways hold data.
  assign victim_s     = !way0_s.valid ? 1'b0 : (!way1_s.valid ? 1'b1 : lru_q[req_s.idx]);
  assign vic_dirty_s  = victim_s ? (way1_s.valid && way1_s.dirty) : (way0_s.valid && way0_s.dirty);
  assign vicf_s       = victim_q ? way1_s : way0_s;
  assign flf_s        = frames_q[cnt_q[3]][cnt_q[2:0]];
  assign req_v_s      = dmemREN || dmemWEN;
  assign sc_s         = dmemWEN && datomic;
  assign ll_s         = dmemREN && !dmemWEN && datomic;
  assign link_match_s = linkvalid_q && (link_q == dmemaddr[31:2]);

  // State register, frame array, LRU bits, link register and flush counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int w = 0; w < 2; w++) begin
        for (int s = 0; s < DSETS; s++) begin
          frames_q[w][s] <= '0;
        end
      end
      lru_q       <= '0;
      link_q      <= '0;
      linkvalid_q <= 1'b0;
      state_q     <= IDLE;
      victim_q    <= 1'b0;
      cnt_q       <= 4'd0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (cnt_inc_s) cnt_q <= cnt_q + 4'd1;
      if (lru_upd_s) lru_q[req_s.idx] <= ~hit1_s;
      if (wr_hit_s) begin
        frames_q[hit1_s][req_s.idx].data[req_s.blkoff] <= dmemstore;
        frames_q[hit1_s][req_s.idx].dirty              <= 1'b1;
      end
      if (fill_s) frames_q[victim_q][req_s.idx].data[fill_word_s] <= dload;
      if (fill_done_s) begin
        frames_q[victim_q][req_s.idx].valid <= 1'b1;
        frames_q[victim_q][req_s.idx].dirty <= 1'b0;
        frames_q[victim_q][req_s.idx].tag   <= req_s.tag;
      end
      if (fclr_s) frames_q[cnt_q[3]][cnt_q[2:0]].dirty <= 1'b0;
      if (link_set_s) begin
        link_q      <= dmemaddr[31:2];
        linkvalid_q <= 1'b1;
      end else if (link_clr_s) begin
        linkvalid_q <= 1'b0;
      end
    end
  end

  // Next state, datapath response, memory handshake and array update strobes.
  always_comb begin
    state_d     = state_q;
    victim_d    = victim_q;
    dhit        = 1'b0;
    dmemload    = 32'd0;
    flushed     = 1'b0;
    dREN        = 1'b0;
    dWEN        = 1'b0;
    daddr       = 32'd0;
    dstore      = 32'd0;
    wr_hit_s    = 1'b0;
    lru_upd_s   = 1'b0;
    fill_s      = 1'b0;
    fill_word_s = 1'b0;
    fill_done_s = 1'b0;
    link_set_s  = 1'b0;
    link_clr_s  = 1'b0;
    fclr_s      = 1'b0;
    cnt_inc_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = FLUSH;
        end else if (sc_s && !link_match_s) begin
          dhit = 1'b1;
        end else if (req_v_s && hit_s) begin
          dhit       = 1'b1;
          lru_upd_s  = 1'b1;
          wr_hit_s   = dmemWEN;
          link_set_s = ll_s;
          link_clr_s = dmemWEN && link_match_s;
          dmemload   = sc_s ? 32'd1 : (dmemWEN ? 32'd0 : hitf_s.data[req_s.blkoff]);
        end else if (req_v_s) begin
          victim_d = victim_s;
          state_d  = vic_dirty_s ? WB0 : LD0;
        end else begin
          state_d = IDLE;
        end
      end
      WB0, WB1: begin
        dWEN   = 1'b1;
        daddr  = blk_addr(vicf_s.tag, req_s.idx, state_q == WB1);
        dstore = vicf_s.data[state_q == WB1];
        if (!dwait) state_d = (state_q == WB0) ? WB1 : LD0;
        else        state_d = state_q;
      end
      LD0, LD1: begin
        dREN        = 1'b1;
        daddr       = blk_addr(req_s.tag, req_s.idx, state_q == LD1);
        fill_word_s = (state_q == LD1);
        if (!dwait) begin
          fill_s      = 1'b1;
          fill_done_s = (state_q == LD1);
          state_d     = (state_q == LD0) ? LD1 : (halt ? FLUSH : IDLE);
        end else begin
          state_d = state_q;
        end
      end
      FLUSH: begin
        if (flf_s.valid && flf_s.dirty) begin
          state_d = FWB0;
        end else begin
          cnt_inc_s = (cnt_q != 4'd15);
          state_d   = (cnt_q == 4'd15) ? DONE : FLUSH;
        end
      end
      FWB0, FWB1: begin
        dWEN   = 1'b1;
        daddr  = blk_addr(flf_s.tag, cnt_q[2:0], state_q == FWB1);
        dstore = flf_s.data[state_q == FWB1];
        if (dwait) begin
          state_d = state_q;
        end else if (state_q == FWB0) begin
          state_d = FWB1;
        end else begin
          fclr_s    = 1'b1;
          cnt_inc_s = (cnt_q != 4'd15);
          state_d   = (cnt_q == 4'd15) ? DONE : FLUSH;
        end
      end
      DONE: begin
        flushed = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: expected memory transfers are queued with each
// request and checked as the cache completes them against a simple memory model.
module tb_dcache;

  logic        CLK, nRST, halt, dmemREN, dmemWEN, datomic;
  logic [31:0] dmemaddr, dmemstore, dmemload, daddr, dstore, dload;
  logic        dhit, flushed, dREN, dWEN, dwait;

  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } xfer_t;
  xfer_t       exp_q[$];
  logic [31:0] mem [0:1023];
  int          lat, wcnt, n_cmp, n_err;
  bit          hold_wait;

  dcache dut (
    .CLK(CLK), .nRST(nRST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .datomic(datomic), .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit),
    .dmemload(dmemload), .flushed(flushed), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] defval(input logic [31:0] a);
    return 32'h5A00_0000 | a;
  endfunction

  assign dwait = (dREN || dWEN) && (hold_wait || (wcnt < lat));
  assign dload = mem[daddr[11:2]];

  always @(posedge CLK) begin
    if (!(dREN || dWEN) || !dwait) wcnt <= 0;
    else                           wcnt <= wcnt + 1;
  end

  initial begin : monitor
    xfer_t e;
    forever begin
      @(negedge CLK);
      if (nRST && (dREN || dWEN) && !dwait) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL xfer_unexpected: got wr=%0b addr=%h data=%h, required no transfer", dWEN, daddr, dstore);
        end else begin
          e = exp_q.pop_front();
          if (dWEN !== e.wr || daddr !== e.addr || (e.wr && dstore !== e.data)) begin
            n_err++;
            $display("FAIL xfer: got wr=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                     dWEN, daddr, dstore, e.wr, e.addr, e.data);
          end
        end
        if (dWEN) mem[daddr[11:2]] = dstore;
      end
    end
  end

  task automatic push(input bit wr, input logic [31:0] a, input logic [31:0] d);
    xfer_t x;
    x.wr = wr; x.addr = a; x.data = d;
    exp_q.push_back(x);
  endtask

  task automatic push_fill(input logic [31:0] a);
    push(1'b0, a, 32'd0);
    push(1'b0, a + 32'd4, 32'd0);
  endtask

  task automatic apply_reset();
    nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
    hold_wait = 1'b0; lat = 0;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  // Drives one request until dhit (cycle index of the hit returned) or budget expiry.
  task automatic do_req(input bit ren, input bit wen, input bit at, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] ld, output int cyc, output bit hit);
    dmemREN = ren; dmemWEN = wen; datomic = at; dmemaddr = a; dmemstore = d;
    hit = 1'b0; cyc = -1; ld = 32'd0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge CLK);
      if (dhit) begin hit = 1'b1; ld = dmemload; cyc = i; end
    end
    @(posedge CLK); #1;
    dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
    dmemaddr = 32'd0; dmemstore = 32'd0; hold_wait = 1'b0; lat = 0;
    #1;
    n_cmp++;
    if ({dhit, flushed, dREN, dWEN} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl: got %b, required 0000", {dhit, flushed, dREN, dWEN});
    end
    n_cmp++;
    if ({dmemload, daddr, dstore} !== 96'd0) begin
      n_err++; $display("FAIL reset_bus: got %h %h %h, required all zero", dmemload, daddr, dstore);
    end
    apply_reset();
  endtask

  task automatic test_clean_miss();
    logic [31:0] ld; int cyc; bit hit;
    lat = 2;
    push_fill(32'h100);
    do_req(1'b1, 1'b0, 1'b0, 32'h100, 32'd0, ld, cyc, hit);
    n_cmp++;
    if (!hit || ld !== defval(32'h100)) begin
      n_err++; $display("FAIL clean_miss_load: got hit=%0b data=%h, required hit=1 data=%h", hit, ld, defval(32'h100));
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL clean_miss_xfers: got %0d outstanding, required 0", exp_q.size());
    end
    lat = 0;
  endtask

  task automatic test_lru_evict();
    logic [31:0] ld; int cyc; bit hit;
    do_req(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, ld, cyc, hit);
    n_cmp++;
    if (!hit || cyc != 0) begin
      n_err++; $display("FAIL store_hit: got hit=%0b cycle=%0d, required hit=1 cycle=0", hit, cyc);
    end
    push_fill(32'h140);
    do_req(1'b1, 1'b0, 1'b0, 32'h140, 32'd0, ld, cyc, hit);
    n_cmp++;
    if (ld !== defval(32'h140) || cyc != 3) begin
      n_err++; $display("FAIL clean_miss_lat: got data=%h cycle=%0d, required data=%h cycle=3", ld, cyc, defval(32'h140));
    end
    push(1'b1, 32'h100, 32'hDEAD_BEEF);
    push(1'b1, 32'h104, defval(32'h104));
    push_fill(32'h180);
    do_req(1'b1, 1'b0, 1'b0, 32'h180, 32'd0, ld, cyc, hit);
    n_cmp++;
    if (ld !== defval(32'h180) || cyc != 5) begin
      n_err++; $display("FAIL dirty_miss_lat: got data=%h cycle=%0d, required data=%h cycle=5", ld, cyc, defval(32'h180));
    end
    push_fill(32'h100);
    do_req(1'b1, 1'b0, 1'b0, 32'h100, 32'd0, ld, cyc, hit);
    n_cmp++;
    if (ld !== 32'hDEAD_BEEF || exp_q.size() != 0) begin
      n_err++; $display("FAIL reload_after_wb: got data=%h left=%0d, required data=deadbeef left=0", ld, exp_q.size());
    end
  endtask

  task automatic test_llsc();
    logic [31:0] ld; int cyc; bit hit;
    apply_reset();
    push_fill(32'h200);
    do_req(1'b1, 1'b0, 1'b1, 32'h200, 32'd0, ld, cyc, hit);
    do_req(1'b0, 1'b1, 1'b1, 32'h200, 32'd5, ld, cyc, hit);
    n_cmp++;
    if (!hit || ld !== 32'd1 || cyc != 0) begin
      n_err++; $display("FAIL sc_success: got hit=%0b data=%h cycle=%0d, required 1/1/0", hit, ld, cyc);
    end
    push_fill(32'h240);
    do_req(1'b1, 1'b0, 1'b0, 32'h240, 32'd0, ld, cyc, hit);
    push(1'b1, 32'h200, 32'd5);
    push(1'b1, 32'h204, defval(32'h204));
    push_fill(32'h280);
    do_req(1'b1, 1'b0, 1'b0, 32'h280, 32'd0, ld, cyc, hit);
    push_fill(32'h200);
    do_req(1'b1, 1'b0, 1'b1, 32'h200, 32'd0, ld, cyc, hit);
    n_cmp++;
    if (ld !== 32'd5) begin
      n_err++; $display("FAIL sc_value_in_mem: got %h, required 00000005", ld);
    end
    do_req(1'b0, 1'b1, 1'b0, 32'h200, 32'd7, ld, cyc, hit);
    do_req(1'b0, 1'b1, 1'b1, 32'h200, 32'd9, ld, cyc, hit);
    n_cmp++;
    if (!hit || ld !== 32'd0 || cyc != 0) begin
      n_err++; $display("FAIL sc_fail: got hit=%0b data=%h cycle=%0d, required 1/0/0", hit, ld, cyc);
    end
    do_req(1'b1, 1'b0, 1'b0, 32'h200, 32'd0, ld, cyc, hit);
    n_cmp++;
    if (ld !== 32'd7) begin
      n_err++; $display("FAIL sc_fail_nowrite: got %h, required 00000007", ld);
    end
  endtask

  task automatic test_flush();
    logic [31:0] ld; int cyc; bit hit, done;
    logic [31:0] a [4];
    logic [31:0] d [4];
    apply_reset();
    a[0] = 32'h000; a[1] = 32'h040; a[2] = 32'h038; a[3] = 32'h078;
    for (int i = 0; i < 4; i++) begin
      d[i] = 32'h1111_0000 + i;
      push_fill(a[i]);
      do_req(1'b0, 1'b1, 1'b0, a[i], d[i], ld, cyc, hit);
      n_cmp++;
      if (!hit || cyc != 3) begin
        n_err++; $display("FAIL store_miss_%0d: got hit=%0b cycle=%0d, required hit=1 cycle=3", i, hit, cyc);
      end
    end
    for (int i = 0; i < 4; i++) begin
      push(1'b1, a[(i == 1) ? 2 : ((i == 2) ? 1 : i)], d[(i == 1) ? 2 : ((i == 2) ? 1 : i)]);
      push(1'b1, a[(i == 1) ? 2 : ((i == 2) ? 1 : i)] + 32'd4, defval(a[(i == 1) ? 2 : ((i == 2) ? 1 : i)] + 32'd4));
    end
    halt = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge CLK);
      done = flushed;
    end
    n_cmp++;
    if (!done || exp_q.size() != 0) begin
      n_err++; $display("FAIL flush_done: got flushed=%0b left=%0d, required flushed=1 left=0", done, exp_q.size());
    end
    @(posedge CLK); #1;
    dmemREN = 1'b1; dmemaddr = 32'h000;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (dhit !== 1'b0 || flushed !== 1'b1) begin
        n_err++; $display("FAIL flush_absorb: got dhit=%0b flushed=%0b, required 0/1", dhit, flushed);
      end
    end
    @(posedge CLK); #1;
    dmemREN = 1'b0; halt = 1'b0;
  endtask

  task automatic test_reset_mid_ld();
    logic [31:0] ld; int cyc; bit hit, seen;
    apply_reset();
    hold_wait = 1'b1;
    dmemREN = 1'b1; dmemaddr = 32'h300;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      seen = dREN;
    end
    #2 nRST = 1'b0;
    #1;
    n_cmp++;
    if (!seen || dREN !== 1'b0) begin
      n_err++; $display("FAIL async_abort: got seen=%0b dREN=%0b, required seen=1 dREN=0", seen, dREN);
    end
    dmemREN = 1'b0; hold_wait = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
    push_fill(32'h300);
    do_req(1'b1, 1'b0, 1'b0, 32'h300, 32'd0, ld, cyc, hit);
    n_cmp++;
    if (ld !== defval(32'h300) || cyc != 3 || exp_q.size() != 0) begin
      n_err++; $display("FAIL remiss_after_reset: got data=%h cycle=%0d left=%0d, required %h/3/0", ld, cyc, exp_q.size(), defval(32'h300));
    end
  endtask

  task automatic test_dwait_hold();
    logic [31:0] ld; int cyc; bit hit, seen;
    apply_reset();
    push_fill(32'h400);
    do_req(1'b0, 1'b1, 1'b0, 32'h400, 32'hCAFE_F00D, ld, cyc, hit);
    push_fill(32'h440);
    do_req(1'b1, 1'b0, 1'b0, 32'h440, 32'd0, ld, cyc, hit);
    hold_wait = 1'b1;
    dmemREN = 1'b1; dmemaddr = 32'h480;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      seen = dWEN;
    end
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge CLK);
      n_cmp++;
      if (dWEN !== 1'b1 || daddr !== 32'h400 || dstore !== 32'hCAFE_F00D) begin
        n_err++; $display("FAIL wb_hold_%0d: got dWEN=%0b addr=%h data=%h, required 1/00000400/cafef00d", i, dWEN, daddr, dstore);
      end
    end
    push(1'b1, 32'h400, 32'hCAFE_F00D);
    push(1'b1, 32'h404, defval(32'h404));
    push_fill(32'h480);
    @(posedge CLK); #1;
    hold_wait = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge CLK);
      if (dhit) begin hit = 1'b1; ld = dmemload; end
    end
    @(posedge CLK); #1;
    dmemREN = 1'b0;
    n_cmp++;
    if (!hit || ld !== defval(32'h480) || exp_q.size() != 0) begin
      n_err++; $display("FAIL wb_release: got hit=%0b data=%h left=%0d, required 1/%h/0", hit, ld, exp_q.size(), defval(32'h480));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = defval(i * 4);
    n_cmp = 0; n_err = 0;
    test_reset();
    test_clean_miss();
    test_lru_evict();
    test_llsc();
    test_flush();
    test_reset_mid_ld();
    test_dwait_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
